updown_counter: RTL and testbench

Parametrised synchronous up/down counter with a built-in set/reset direction register, the clocked successor to the lab's direction latch plus counter pair. Direction is set to UP or DOWN by pulse inputs; counting advances on an enable tick with wrap or saturate behaviour at a configurable top value. Parallel load, terminal-count pulse and a set/reset conflict flag are included. Sits between the button/tick front end and the display driver.

---
 rtl/updown_counter.sv | 80 ++++++++
 tb/tb_updown_counter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/updown_counter.sv
// updown_counter: up/down counter with set/reset direction register.
// Define UPDN_BOUNCE_EN to reverse direction at the limits instead of wrap/saturate.
module updown_counter #(
    parameter int WIDTH    = 4,
    parameter int MAX      = 2**WIDTH-1,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             set_up,
    input  logic             set_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             dir,
    output logic             tc,
    output logic             conflict
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

    logic             dir_res;
    logic             dir_d;
    logic             tc_d;
    logic             hit;
    logic [WIDTH-1:0] count_d;

    // Resolve S/R pulses into this cycle's direction; conflict keeps dir.
    always_comb begin
        dir_res = dir;
        unique case (1'b1)
            set_up & ~set_down: dir_res = 1'b1;
            set_down & ~set_up: dir_res = 1'b0;
            default:            dir_res = dir;
        endcase
    end

    assign hit = dir_res ? (count >= MAX_V) : (count == '0);

    // Next count/dir/tc: load beats en; boundary steps raise tc.
    always_comb begin
        count_d = count;
        dir_d   = dir_res;
        tc_d    = 1'b0;
        if (load) begin
            count_d = (load_val > MAX_V) ? MAX_V : load_val;
        end else if (en) begin
            if (!hit) begin
                count_d = dir_res ? count + ONE : count - ONE;
            end else begin
                tc_d = 1'b1;
`ifdef UPDN_BOUNCE_EN
                count_d = dir_res ? MAX_V - ONE : ONE;
                dir_d   = ~dir_res;
`else
                if (SATURATE == 0)
                    count_d = dir_res ? '0 : MAX_V;
`endif
            end
        end
    end

    // All outputs registered; synchronous reset overrides everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            count    <= '0;
            dir      <= 1'b1;
            tc       <= 1'b0;
            conflict <= 1'b0;
        end else begin
            count    <= count_d;
            dir      <= dir_d;
            tc       <= tc_d;
            conflict <= set_up & set_down;
        end
    end

endmodule

// File: tb/tb_updown_counter.sv
// tb_updown_counter: directed checks on four counter configurations.
// Instances: 0 = MAX15 wrap, 1 = MAX9 sat, 2 = MAX9 wrap, 3 = MAX3 wrap.
module tb_updown_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  [4];
    logic       su  [4];
    logic       sd  [4];
    logic       ld  [4];
    logic [3:0] lv  [4];
    logic [3:0] cnt [4];
    logic       dir [4];
    logic       tc  [4];
    logic       cfl [4];

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        updown_counter #(
            .WIDTH(4),
            .MAX(g == 0 ? 15 : (g == 3 ? 3 : 9)),
            .SATURATE(g == 1 ? 1 : 0)
        ) u_dut (
            .clk(clk),
            .rst(rst),
            .en(en[g]),
            .set_up(su[g]),
            .set_down(sd[g]),
            .load(ld[g]),
            .load_val(lv[g]),
            .count(cnt[g]),
            .dir(dir[g]),
            .tc(tc[g]),
            .conflict(cfl[g])
        );
    end

    task automatic check(input string tag, input int got, input int exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic idle();
        for (int i = 0; i < 4; i++) begin
            en[i] = 1'b0;
            su[i] = 1'b0;
            sd[i] = 1'b0;
            ld[i] = 1'b0;
            lv[i] = 4'd0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input int i, input int c,
                             input int d, input int t, input int k);
        check({tag, ".count"}, int'(cnt[i]), c);
        check({tag, ".dir"}, int'(dir[i]), d);
        check({tag, ".tc"}, int'(tc[i]), t);
        check({tag, ".conflict"}, int'(cfl[i]), k);
    endtask

    initial begin
        idle();
        rst = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 4; i++)
            check_all($sformatf("reset%0d", i), i, 0, 1, 0, 0);
        rst = 1'b0;

`ifndef UPDN_BOUNCE_EN
        // Wrap count-up on MAX=15: tc only after 15->0.
        en[0] = 1'b1;
        for (int s = 1; s <= 17; s++) begin
            tick();
            check($sformatf("up%0d.count", s), int'(cnt[0]), s % 16);
            check($sformatf("up%0d.tc", s), int'(tc[0]), (s == 16) ? 1 : 0);
            check($sformatf("up%0d.dir", s), int'(dir[0]), 1);
        end
        idle();

        // Saturate at MAX=9: load clamps, tc held on every blocked step.
        ld[1] = 1'b1;
        lv[1] = 4'd12;
        tick();
        check_all("sat_load", 1, 9, 1, 0, 0);
        ld[1] = 1'b0;
        en[1] = 1'b1;
        for (int s = 0; s < 3; s++) begin
            tick();
            check_all($sformatf("sat_hold%0d", s), 1, 9, 1, 1, 0);
        end
        ld[1] = 1'b1;
        lv[1] = 4'd3;
        tick();
        check_all("sat_loadwin", 1, 3, 1, 0, 0);
        idle();
        tick();
        check_all("sat_idle", 1, 3, 1, 0, 0);
        ld[1] = 1'b1;
        lv[1] = 4'd0;
        sd[1] = 1'b1;
        tick();
        check_all("sat_ld0", 1, 0, 0, 0, 0);
        idle();
        en[1] = 1'b1;
        tick();
        check_all("sat_floor", 1, 0, 0, 1, 0);
        idle();

        // Wrap count-down on MAX=9: 1 -> 0 -> 9.
        ld[2] = 1'b1;
        lv[2] = 4'd1;
        sd[2] = 1'b1;
        tick();
        check_all("dn_load", 2, 1, 0, 0, 0);
        idle();
        en[2] = 1'b1;
        tick();
        check_all("dn_to0", 2, 0, 0, 0, 0);
        tick();
        check_all("dn_wrap", 2, 9, 0, 1, 0);
        tick();
        check_all("dn_8", 2, 8, 0, 0, 0);
        idle();
`else
        // Bounce on MAX=3: reverse at each limit.
        begin
            int exp_c [8] = '{1, 2, 3, 2, 1, 0, 1, 2};
            int exp_d [8] = '{1, 1, 1, 0, 0, 0, 1, 1};
            int exp_t [8] = '{0, 0, 0, 1, 0, 0, 1, 0};
            en[3] = 1'b1;
            for (int s = 0; s < 8; s++) begin
                tick();
                check_all($sformatf("bnc%0d", s), 3,
                          exp_c[s], exp_d[s], exp_t[s], 0);
            end
            idle();
        end
`endif

        // Same-edge S/R steers the step; conflict holds dir.
        ld[0] = 1'b1;
        lv[0] = 4'd5;
        tick();
        check_all("sr_load", 0, 5, 1, 0, 0);
        idle();
        sd[0] = 1'b1;
        en[0] = 1'b1;
        tick();
        check_all("sr_down", 0, 4, 0, 0, 0);
        idle();
        su[0] = 1'b1;
        sd[0] = 1'b1;
        tick();
        check_all("sr_cfl", 0, 4, 0, 0, 1);
        idle();
        tick();
        check_all("sr_cfl_end", 0, 4, 0, 0, 0);

        // Reset mid-count overrides load/en/S/R.
        ld[0] = 1'b1;
        lv[0] = 4'd7;
        tick();
        check_all("rst_pre", 0, 7, 0, 0, 0);
        rst   = 1'b1;
        en[0] = 1'b1;
        lv[0] = 4'd3;
        sd[0] = 1'b1;
        tick();
        check_all("rst_mid", 0, 0, 1, 0, 0);
        rst = 1'b0;
        idle();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
